// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the configurable UART transmitter.
// The UART_TX_BREAK_EN macro adds the e_break state.
package uart_pkg;

  localparam int unsigned uart_min_data_bits_gp   = 5;
  localparam int unsigned uart_min_clk_per_bit_gp = 2;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {
    e_reset  = 3'd0,
    e_idle   = 3'd1,
    e_start  = 3'd2,
    e_data   = 3'd3,
    e_parity = 3'd4,
    e_stop   = 3'd5,
    e_break  = 3'd6
  } uart_tx_state_e;
`else
  typedef enum logic [2:0] {
    e_reset  = 3'd0,
    e_idle   = 3'd1,
    e_start  = 3'd2,
    e_data   = 3'd3,
    e_parity = 3'd4,
    e_stop   = 3'd5
  } uart_tx_state_e;
`endif

  // Clock divisor is held at 32 bits so any divisor input width up to 32 fits.
  typedef struct packed {
    logic [31:0] clk_per_bit;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
  } uart_cfg_s;

  function automatic logic uart_parity(input logic [15:0] data,
                                       input logic [3:0]  n,
                                       input logic        odd);
    logic p;
    p = odd;
    for (int i = 0; i < 16; i++) begin
      p = p ^ (data[i] & (4'(i) < n));
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO with occupancy count; synchronous active-low reset.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 9
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [width_p-1:0]           wdata,
  input  logic                         pop,
  output logic [width_p-1:0]           rdata,
  output logic [$clog2(els_p+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r;
  logic [ptr_w_lp-1:0] rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  assign full   = (count_r == cnt_w_lp'(els_p));
  assign empty  = (count_r == '0);
  assign rdata  = mem_r[rptr_r];
  assign count  = count_r;
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + ptr_w_lp'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + ptr_w_lp'(1);
      end
      count_r <= count_r + cnt_w_lp'(push_s) - cnt_w_lp'(pop_s);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with input FIFO and back-to-back framing.
// Define UART_TX_BREAK_EN to add the break_i input and the e_break state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned clk_div_width_p = 16,
  parameter int unsigned max_data_bits_p = 9,
  parameter int unsigned fifo_els_p      = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [clk_div_width_p-1:0]        cfg_clk_per_bit_i,
  input  logic [3:0]                        cfg_data_bits_i,
  input  logic                              cfg_parity_en_i,
  input  logic                              cfg_parity_odd_i,
  input  logic                              cfg_two_stop_i,
`ifdef UART_TX_BREAK_EN
  input  logic                              break_i,
`endif
  input  logic                              data_v_i,
  input  logic [max_data_bits_p-1:0]        data_i,
  output logic                              data_ready_and_o,
  output logic                              tx_o,
  output logic                              busy_o,
  output logic                              tx_done_o,
  output logic [$clog2(fifo_els_p+1)-1:0]   fifo_count_o
);

  localparam int unsigned cnt_w_lp = $clog2(fifo_els_p + 1);

  logic                       push_s, pop_s, full_s, empty_s, launch_s, bit_end_s;
  logic [max_data_bits_p-1:0] fifo_data_s;
  logic [cnt_w_lp-1:0]        fifo_count_s, count_next_s;
  uart_tx_state_e             state_r, state_n;
  logic [clk_div_width_p-1:0] cnt_r, cnt_n;
  logic [3:0]                 idx_r, idx_n;
  logic [max_data_bits_p-1:0] payload_r, payload_n;
  logic [15:0]                payload_ext_s;
  uart_cfg_s                  cfg_r, cfg_n, cfg_live_s;
  logic                       tx_r, tx_n, done_r, done_n, busy_r, busy_n;

  assign data_ready_and_o = reset_n_i & ~full_s;
  assign push_s           = data_v_i & data_ready_and_o;
  assign count_next_s     = fifo_count_s + cnt_w_lp'(push_s) - cnt_w_lp'(pop_s);
  assign bit_end_s        = (32'(cnt_r) == (cfg_r.clk_per_bit - 32'd1));

  uart_tx_fifo #(.els_p(fifo_els_p), .width_p(max_data_bits_p)) fifo (
    .clk(clk_i), .reset_n(reset_n_i), .push(push_s), .wdata(data_i), .pop(pop_s),
    .rdata(fifo_data_s), .count(fifo_count_s), .full(full_s), .empty(empty_s)
  );

  // Live configuration with out-of-range divisor and width clamped.
  always_comb begin
    if (32'(cfg_clk_per_bit_i) < 32'(uart_min_clk_per_bit_gp)) begin
      cfg_live_s.clk_per_bit = 32'(uart_min_clk_per_bit_gp);
    end else begin
      cfg_live_s.clk_per_bit = 32'(cfg_clk_per_bit_i);
    end
    if (cfg_data_bits_i < 4'(uart_min_data_bits_gp)) begin
      cfg_live_s.data_bits = 4'(uart_min_data_bits_gp);
    end else if (cfg_data_bits_i > 4'(max_data_bits_p)) begin
      cfg_live_s.data_bits = 4'(max_data_bits_p);
    end else begin
      cfg_live_s.data_bits = cfg_data_bits_i;
    end
    cfg_live_s.parity_en  = cfg_parity_en_i;
    cfg_live_s.parity_odd = cfg_parity_odd_i;
    cfg_live_s.two_stop   = cfg_two_stop_i;
  end

  // Next-state logic; launch_s starts a frame from the FIFO head with fresh config.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    idx_n     = idx_r;
    payload_n = payload_r;
    cfg_n     = cfg_r;
    done_n    = 1'b0;
    launch_s  = 1'b0;
    pop_s     = 1'b0;
    case (state_r)
      e_reset: state_n = e_idle;
      e_idle: begin
`ifdef UART_TX_BREAK_EN
        if (break_i) begin
          state_n = e_break;
          cnt_n   = '0;
          idx_n   = 4'd0;
        end else
`endif
        if (!empty_s) begin
          launch_s = 1'b1;
        end else begin
          state_n = e_idle;
        end
      end
      e_start: begin
        if (bit_end_s) begin
          cnt_n   = '0;
          idx_n   = 4'd0;
          state_n = e_data;
        end else begin
          cnt_n = cnt_r + clk_div_width_p'(1);
        end
      end
      e_data: begin
        if (bit_end_s) begin
          cnt_n = '0;
          if (idx_r == (cfg_r.data_bits - 4'd1)) begin
            idx_n   = 4'd0;
            state_n = cfg_r.parity_en ? e_parity : e_stop;
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else begin
          cnt_n = cnt_r + clk_div_width_p'(1);
        end
      end
      e_parity: begin
        if (bit_end_s) begin
          cnt_n   = '0;
          idx_n   = 4'd0;
          state_n = e_stop;
        end else begin
          cnt_n = cnt_r + clk_div_width_p'(1);
        end
      end
      e_stop: begin
        if (bit_end_s) begin
          cnt_n = '0;
          if (idx_r == {3'b000, cfg_r.two_stop}) begin
            done_n = 1'b1;
            idx_n  = 4'd0;
`ifdef UART_TX_BREAK_EN
            if (break_i) begin
              state_n = e_break;
            end else
`endif
            if (!empty_s) begin
              launch_s = 1'b1;
            end else begin
              state_n = e_idle;
            end
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else begin
          cnt_n = cnt_r + clk_div_width_p'(1);
        end
      end
`ifdef UART_TX_BREAK_EN
      // idx_r 0: line held low; idx_r 1: one bit time of mark before idling.
      e_break: begin
        if (idx_r == 4'd0) begin
          if (!break_i) begin
            idx_n = 4'd1;
            cnt_n = '0;
          end else begin
            state_n = e_break;
          end
        end else if (32'(cnt_r) == (cfg_live_s.clk_per_bit - 32'd1)) begin
          idx_n   = 4'd0;
          state_n = e_idle;
        end else begin
          cnt_n = cnt_r + clk_div_width_p'(1);
        end
      end
`endif
      default: state_n = e_reset;
    endcase
    if (launch_s) begin
      pop_s     = 1'b1;
      payload_n = fifo_data_s;
      cfg_n     = cfg_live_s;
      cnt_n     = '0;
      idx_n     = 4'd0;
      state_n   = e_start;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Line level and busy flag for the cycle after the edge, so both come from flops.
  always_comb begin
    payload_ext_s = 16'(payload_n);
    tx_n          = 1'b1;
    case (state_n)
      e_start:  tx_n = 1'b0;
      e_data:   tx_n = payload_ext_s[idx_n];
      e_parity: tx_n = uart_parity(payload_ext_s, cfg_n.data_bits, cfg_n.parity_odd);
`ifdef UART_TX_BREAK_EN
      e_break:  tx_n = (idx_n != 4'd0);
`endif
      default:  tx_n = 1'b1;
    endcase
    busy_n = ((state_n != e_reset) && (state_n != e_idle)) || (count_next_s != '0);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= e_reset;
      cnt_r     <= '0;
      idx_r     <= 4'd0;
      payload_r <= '0;
      cfg_r     <= '0;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      idx_r     <= idx_n;
      payload_r <= payload_n;
      cfg_r     <= cfg_n;
      tx_r      <= tx_n;
      done_r    <= done_n;
      busy_r    <= busy_n;
    end
  end

  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign tx_done_o    = done_r;
  assign fifo_count_o = fifo_count_s;

endmodule
